nibble_serial_add_ctrl: RTL

//  Sequences one shared 4-bit ripple adder (A,B,Cin -> S,Cout) to add two wide

---
 rtl/nibble_serial_add_ctrl.sv | 98 +++++++++
 1 files changed

// File: rtl/nibble_serial_add_ctrl.sv
// Sequencer that steps one shared 4-bit adder across wide operands,
// LSB nibble first, with the carry chained from each nibble into the next.
module nibble_serial_add_ctrl #(
   parameter int unsigned NIBBLES = 4,
   localparam int unsigned W = 4 * NIBBLES
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] op_a,
   input  logic [W-1:0] op_b,
   input  logic         cin,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] sum,
   output logic         cout,
   output logic [3:0]   add_a,
   output logic [3:0]   add_b,
   output logic         add_cin,
   input  logic [3:0]   add_s,
   input  logic         add_cout
);

   localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state;
   logic [IDX_W-1:0]   idx;
   logic               carry;
   logic [W-1:0]       a_r;
   logic [W-1:0]       b_r;

   // Controller: operand capture, per-nibble result capture, carry chaining
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         idx   <= '0;
         carry <= 1'b0;
         a_r   <= '0;
         b_r   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  a_r   <= op_a;
                  b_r   <= op_b;
                  carry <= cin;
                  idx   <= '0;
                  sum   <= '0;
                  cout  <= 1'b0;
                  state <= S_RUN;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_RUN: begin
               sum[{idx, 2'b00} +: 4] <= add_s;
               carry                  <= add_cout;
               if (idx == LAST_IDX) begin
                  cout  <= add_cout;
                  idx   <= '0;
                  state <= S_DONE;
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end
            default: begin
               idx   <= '0;
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy = (state == S_RUN);
   assign done = (state == S_DONE);

   // Adder operands are only presented while running; quiet otherwise
   always_comb begin
      add_a   = 4'h0;
      add_b   = 4'h0;
      add_cin = 1'b0;
      if (state == S_RUN) begin
         add_a   = a_r[{idx, 2'b00} +: 4];
         add_b   = b_r[{idx, 2'b00} +: 4];
         add_cin = carry;
      end
   end

endmodule
